// File: rtl/spa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : spa_pkg                                                      |
// | Description : Shared types and constants for the SPA key-attempt           |
// |               controller: FSM state encoding, frame mode values and the    |
// |               default demo secret byte.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    RUN  = 3'd2,
    BUFF = 3'd3,
    SEND = 3'd4
  } spa_state_e;

  // Header bit 0 selects the response type.
  localparam logic SPA_MODE_ECHO = 1'b0;
  localparam logic SPA_MODE_CMP  = 1'b1;

  localparam logic [7:0] SPA_KEY_DEFAULT = 8'hAC;

endpackage
`default_nettype wire

// File: rtl/spa_round_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spa_round_ctr                                                |
// | Description : Round/cycle counter for the leakage window. A start pulse    |
// |               resets to round 0 cycle 0; while advance_en is high the      |
// |               cycle counter runs 0..ROUND_CYCLES-1 and then steps rounds.  |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk, rst_n       clock, async active-low reset              |
// |               start            begin a new window at round 0              |
// |               advance_en       keep counting (low on the exit cycle)      |
// |               cyc[7:0]         cycle within the current round             |
// |               round_idx        current round                              |
// |               syn              registered first-cycle-of-round pulse      |
// |               round_end        current cycle is the last of the round     |
// |               last_round       current round is KEY_BYTES-1               |
// +----------------------------------------------------------------------------+
module spa_round_ctr #(
  parameter int KEY_BYTES    = 4,
  parameter int ROUND_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       advance_en,
  output logic [7:0]                 cyc,
  output logic [$clog2(KEY_BYTES):0] round_idx,
  output logic                       syn,
  output logic                       round_end,
  output logic                       last_round
);

  localparam int RW = $clog2(KEY_BYTES) + 1;
  localparam logic [7:0]    CYC_LAST   = 8'(ROUND_CYCLES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(KEY_BYTES - 1);

  assign round_end  = (cyc == CYC_LAST);
  assign last_round = (round_idx == ROUND_LAST);

  // syn is asserted for the cycle in which cyc is 0 of a live round, so it is
  // set on the edge that loads cycle 0 and cleared on every other edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= '0;
      round_idx <= '0;
      syn       <= 1'b0;
    end else if (start) begin
      cyc       <= '0;
      round_idx <= '0;
      syn       <= 1'b1;
    end else if (advance_en) begin
      if (round_end) begin
        cyc       <= '0;
        round_idx <= round_idx + RW'(1);
        syn       <= 1'b1;
      end else begin
        cyc       <= cyc + 8'd1;
        syn       <= 1'b0;
      end
    end else begin
      syn <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spa_key_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spa_key_ctrl                                                 |
// | Description : Key-attempt controller. Receives header + KEY_BYTES attempt  |
// |               bytes, replays them through a round-based leakage window,    |
// |               then returns an echo or a match count over AXI-stream.       |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk, rst_n              clock, async active-low reset       |
// |               secret[8*KEY_BYTES]     reference key, byte i at [8i+:8]    |
// |               rx_tdata/tvalid/tready  attempt stream in                   |
// |               tx_tdata/tvalid/tready  response stream out                 |
// |               leak_data               attempt[i]|secret[i] during RUN     |
// |               trg, syn                window / round-start markers        |
// |               busy                    not IDLE                            |
// +----------------------------------------------------------------------------+
module spa_key_ctrl
  import spa_pkg::*;
#(
  parameter int KEY_BYTES    = 4,
  parameter int ROUND_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*KEY_BYTES-1:0] secret,
  input  logic [7:0]             rx_tdata,
  input  logic                   rx_tvalid,
  output logic                   rx_tready,
  output logic [7:0]             tx_tdata,
  output logic                   tx_tvalid,
  input  logic                   tx_tready,
  output logic [7:0]             leak_data,
  output logic                   trg,
  output logic                   syn,
  output logic                   busy
);

  localparam int RW = $clog2(KEY_BYTES) + 1;
  localparam logic [RW-1:0] LAST_IDX = RW'(KEY_BYTES - 1);
  localparam logic [7:0]    CYC_LAST = 8'(ROUND_CYCLES - 1);

  spa_state_e             state;
  logic                   mode;
  logic [RW-1:0]          idx;
  logic [RW-1:0]          tx_ptr;
  logic [7:0]             match_cnt;
  logic [8*KEY_BYTES-1:0] attempt;
  logic [8*KEY_BYTES-1:0] attempt_nxt;

  logic [7:0]    cyc;
  logic [RW-1:0] round_idx;
  logic          round_end;
  logic          last_round;

  logic          rx_hs, tx_hs, start, mismatch, run_exit, advance_en;
  logic [RW-1:0] lk_idx;
  logic [RW-1:0] tx_ptr_inc;
  logic [7:0]    leak_nxt;

  assign rx_hs      = rx_tvalid && rx_tready;
  assign tx_hs      = tx_tvalid && tx_tready;
  assign start      = (state == RECV) && rx_hs && (idx == LAST_IDX);
  assign mismatch   = attempt[{round_idx, 3'b000} +: 8] != secret[{round_idx, 3'b000} +: 8];
  // Compare mode bails out at the first mismatching round: this is the leak.
  assign run_exit   = round_end && (last_round || (mode == SPA_MODE_CMP && mismatch));
  assign advance_en = (state == RUN) && !run_exit;
  assign tx_ptr_inc = tx_ptr + RW'(1);

  spa_round_ctr #(
    .KEY_BYTES   (KEY_BYTES),
    .ROUND_CYCLES(ROUND_CYCLES)
  ) u_round_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .advance_en(advance_en),
    .cyc       (cyc),
    .round_idx (round_idx),
    .syn       (syn),
    .round_end (round_end),
    .last_round(last_round)
  );

  // Attempt register next value, so the leak byte for round 0 is correct even
  // when the final received byte is the one it needs (KEY_BYTES == 1).
  always_comb begin
    attempt_nxt = attempt;
    if (state == RECV && rx_hs) begin
      attempt_nxt[{idx, 3'b000} +: 8] = rx_tdata;
    end
  end

  // Round whose leak byte is presented in the next cycle.
  always_comb begin
    lk_idx = round_idx;
    if (start) begin
      lk_idx = '0;
    end else if (round_end) begin
      lk_idx = round_idx + RW'(1);
    end
    leak_nxt = attempt_nxt[{lk_idx, 3'b000} +: 8] | secret[{lk_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= SPA_MODE_ECHO;
      idx       <= '0;
      tx_ptr    <= '0;
      match_cnt <= '0;
      attempt   <= '0;
      rx_tready <= 1'b1;
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
      leak_data <= '0;
      trg       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      attempt <= attempt_nxt;
      case (state)
        IDLE: begin
          if (rx_hs) begin
            mode  <= rx_tdata[0];
            idx   <= '0;
            busy  <= 1'b1;
            state <= RECV;
          end
        end
        RECV: begin
          if (rx_hs) begin
            if (idx == LAST_IDX) begin
              rx_tready <= 1'b0;
              trg       <= 1'b1;
              leak_data <= leak_nxt;
              state     <= RUN;
            end else begin
              idx <= idx + RW'(1);
            end
          end
        end
        RUN: begin
          if (run_exit) begin
            trg       <= 1'b0;
            leak_data <= '0;
            state     <= BUFF;
            if (mode == SPA_MODE_CMP) begin
              match_cnt <= (last_round && !mismatch) ? 8'(KEY_BYTES) : 8'(round_idx);
            end
          end else begin
            leak_data <= leak_nxt;
          end
        end
        BUFF: begin
          tx_ptr    <= '0;
          tx_tvalid <= 1'b1;
          tx_tdata  <= (mode == SPA_MODE_CMP) ? match_cnt : attempt[7:0];
          state     <= SEND;
        end
        SEND: begin
          if (tx_hs) begin
            if (mode == SPA_MODE_CMP || tx_ptr == LAST_IDX) begin
              tx_tvalid <= 1'b0;
              tx_tdata  <= '0;
              rx_tready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              tx_ptr   <= tx_ptr_inc;
              tx_tdata <= attempt[{tx_ptr_inc, 3'b000} +: 8];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_cyc_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RUN) |-> (cyc <= CYC_LAST));

endmodule
`default_nettype wire

// File: tb/tb_spa_key_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spa_key_ctrl                                              |
// | Description : Directed self-checking bench for spa_key_ctrl. Two DUTs:     |
// |               (4 bytes, 16 cycles/round) and (1 byte, 2 cycles/round).     |
// |               Expected response bytes go into a scoreboard queue.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spa_key_ctrl;
  import spa_pkg::*;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       sel       = 1'b0;
  logic [7:0] rx_tdata  = 8'h00;
  logic       rx_tvalid = 1'b0;
  logic       tx_tready = 1'b1;

  logic       rx_tready0, tx_tvalid0, trg0, syn0, busy0;
  logic [7:0] tx_tdata0, leak0;
  logic       rx_tready1, tx_tvalid1, trg1, syn1, busy1;
  logic [7:0] tx_tdata1, leak1;

  logic       cur_rx_tready, cur_tx_tvalid, cur_trg, cur_busy, cur_syn;
  logic [7:0] cur_tx_tdata, cur_leak;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         syn_q[$];
  logic [7:0] leak_q[$];
  int cycle = 0, trg_cnt0 = 0, trg_cnt1 = 0, hs_cnt0 = 0, last_trg0 = 0, txv_rise0 = 0;
  logic txv_prev0 = 1'b0;

  always #5 clk = ~clk;

  spa_key_ctrl #(.KEY_BYTES(4), .ROUND_CYCLES(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .secret({4{SPA_KEY_DEFAULT}}),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid && !sel), .rx_tready(rx_tready0),
    .tx_tdata(tx_tdata0), .tx_tvalid(tx_tvalid0), .tx_tready(tx_tready && !sel),
    .leak_data(leak0), .trg(trg0), .syn(syn0), .busy(busy0)
  );

  spa_key_ctrl #(.KEY_BYTES(1), .ROUND_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .secret(8'h5A),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid && sel), .rx_tready(rx_tready1),
    .tx_tdata(tx_tdata1), .tx_tvalid(tx_tvalid1), .tx_tready(tx_tready && sel),
    .leak_data(leak1), .trg(trg1), .syn(syn1), .busy(busy1)
  );

  assign cur_rx_tready = sel ? rx_tready1 : rx_tready0;
  assign cur_tx_tvalid = sel ? tx_tvalid1 : tx_tvalid0;
  assign cur_tx_tdata  = sel ? tx_tdata1  : tx_tdata0;
  assign cur_trg       = sel ? trg1       : trg0;
  assign cur_syn       = sel ? syn1       : syn0;
  assign cur_busy      = sel ? busy1      : busy0;
  assign cur_leak      = sel ? leak1      : leak0;

  // Monitors: window length, round markers, leak bytes and tx handshakes.
  always @(posedge clk) begin
    cycle     <= cycle + 1;
    trg_cnt0  <= trg_cnt0 + int'(trg0);
    trg_cnt1  <= trg_cnt1 + int'(trg1);
    txv_prev0 <= tx_tvalid0;
    if (trg0) last_trg0 <= cycle;
    if (tx_tvalid0 && !txv_prev0) txv_rise0 <= cycle;
    if (tx_tvalid0 && tx_tready && !sel) hs_cnt0 <= hs_cnt0 + 1;
    if (syn0) begin
      syn_q.push_back(cycle);
      leak_q.push_back(leak0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    while (cur_rx_tready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("rx_timeout", 32'(n), 32'(0));
    @(negedge clk);
    rx_tvalid = 1'b0;
  endtask

  task automatic recv_bytes(input int cnt);
    tx_tready = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      int n;
      logic [7:0] e;
      n = 0;
      while (cur_tx_tvalid !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3000) begin
        check("tx_timeout", 32'(n), 32'(0));
        return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("tx_byte", 32'(cur_tx_tdata), 32'(e));
      @(negedge clk);
    end
  endtask

  task automatic wait_tx_valid();
    int n;
    n = 0;
    while (cur_tx_tvalid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("tx_valid_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int t0, h0, bad;

    // ---------------- reset values
    repeat (3) @(negedge clk);
    check("rst_rx_tready", 32'(cur_rx_tready), 32'(1));
    check("rst_tx_tvalid", 32'(cur_tx_tvalid), 32'(0));
    check("rst_tx_tdata",  32'(cur_tx_tdata),  32'(0));
    check("rst_leak",      32'(cur_leak),      32'(0));
    check("rst_trg",       32'(cur_trg),       32'(0));
    check("rst_syn",       32'(cur_syn),       32'(0));
    check("rst_busy",      32'(cur_busy),      32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- echo
    t0 = trg_cnt0;
    syn_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("echo_busy", 32'(cur_busy), 32'(1));
    recv_bytes(4);
    check("echo_trg_len", 32'(trg_cnt0 - t0), 32'(64));
    check("echo_syn_cnt", 32'(syn_q.size()), 32'(4));
    if (syn_q.size() == 4)
      for (int i = 1; i < 4; i++) check("echo_syn_gap", 32'(syn_q[i] - syn_q[i-1]), 32'(16));
    check("echo_tx_latency", 32'(txv_rise0 - last_trg0), 32'(2));
    check("echo_idle_ready", 32'(cur_rx_tready), 32'(1));

    // ---------------- compare, full match
    t0 = trg_cnt0;
    leak_q.delete();
    exp_q.push_back(8'h04);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(SPA_KEY_DEFAULT);
    recv_bytes(1);
    check("cmp_full_trg_len", 32'(trg_cnt0 - t0), 32'(64));
    check("cmp_full_leak_cnt", 32'(leak_q.size()), 32'(4));
    foreach (leak_q[i]) check("cmp_full_leak", 32'(leak_q[i]), 32'(8'hAC));
    check("cmp_full_done", 32'(cur_tx_tvalid), 32'(0));

    // ---------------- compare, mismatch at byte 1 (header 0xFF: upper bits ignored)
    t0 = trg_cnt0;
    leak_q.delete();
    exp_q.push_back(8'h01);
    send_byte(8'hFF); send_byte(8'hAC); send_byte(8'h00); send_byte(8'hAC); send_byte(8'hAC);
    recv_bytes(1);
    check("cmp_mis_trg_len", 32'(trg_cnt0 - t0), 32'(32));
    check("cmp_mis_leak_cnt", 32'(leak_q.size()), 32'(2));
    foreach (leak_q[i]) check("cmp_mis_leak", 32'(leak_q[i]), 32'(8'hAC));

    // ---------------- back-pressure on an echo response
    h0 = hs_cnt0;
    tx_tready = 1'b0;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    send_byte(8'h10); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    wait_tx_valid();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (cur_tx_tvalid !== 1'b1 || cur_tx_tdata !== 8'hA1 || cur_rx_tready !== 1'b0) bad++;
      @(negedge clk);
    end
    check("bp_hold_stable", 32'(bad), 32'(0));
    recv_bytes(4);
    repeat (3) @(negedge clk);
    check("bp_hs_count", 32'(hs_cnt0 - h0), 32'(4));
    check("bp_tx_idle", 32'(cur_tx_tvalid), 32'(0));

    // ---------------- reset in the middle of RUN
    h0 = hs_cnt0;
    send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    bad = 0;
    while (cur_trg !== 1'b1 && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    check("rr_trg_seen", 32'(cur_trg), 32'(1));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rr_trg",       32'(cur_trg),       32'(0));
    check("rr_busy",      32'(cur_busy),      32'(0));
    check("rr_tx_tvalid", 32'(cur_tx_tvalid), 32'(0));
    check("rr_leak",      32'(cur_leak),      32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("rr_no_emit", 32'(hs_cnt0 - h0), 32'(0));
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    recv_bytes(4);

    // ---------------- KEY_BYTES=1, ROUND_CYCLES=2
    sel = 1'b1;
    @(negedge clk);
    t0 = trg_cnt1;
    exp_q.push_back(8'h01);
    send_byte(8'h01); send_byte(8'h5A);
    recv_bytes(1);
    check("kb1_trg_len", 32'(trg_cnt1 - t0), 32'(2));
    check("kb1_idle", 32'(cur_busy), 32'(0));

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/spa_key_ctrl.md
# spa_key_ctrl

Parametrised key-attempt controller for the side-channel demo target. Receives a framed multi-byte attempt from the UART receive AXI-stream, then replays it through a round-based leakage window. Each round exposes one byte on `leak_data`, with `trg`/`syn` marking the window for the scope. It then returns either an echo of the attempt or a compare result through the UART transmit AXI-stream, and sits between the `uart` instance and the leakage datapath in `top`.

## Interface
Parameters:
- `KEY_BYTES`, 4: attempt/secret length in bytes (1..16).
- `ROUND_CYCLES`, 16: clock cycles per leakage round (2..255).

Ports:
- `clk`  in  1  target clock (divided clock domain).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `secret`  in  8*KEY_BYTES  reference key; byte i = bits [8i+7:8i]; sampled continuously, must be static during RUN.
- `rx_tdata`  in  8  byte from UART receiver.
- `rx_tvalid`  in  1  receiver byte valid.
- `rx_tready`  out  1  controller accepts byte.
- `tx_tdata`  out  8  byte to UART transmitter.
- `tx_tvalid`  out  1  transmit byte valid.
- `tx_tready`  in  1  transmitter accepts byte.
- `leak_data`  out  8  `attempt[i] | secret[i]` for the current round i; 0 outside RUN.
- `trg`  out  1  high for every cycle of RUN.
- `syn`  out  1  one-cycle pulse on the first cycle of each round.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Frame format: header byte, then KEY_BYTES attempt bytes; first attempt byte lands in byte 0.
- Header bit 0 = mode: 0 ECHO, 1 CMP. Bits 7:1 are ignored.
- States:
  - IDLE: `rx_tready`=1. Header handshake latches mode, clears byte index, goes to RECV.
  - RECV: `rx_tready`=1. Each handshake writes `attempt[idx]`. On `idx==KEY_BYTES-1`, go to RUN with round 0 and cycle counter 0.
  - RUN: `rx_tready`=0. Cycle counter counts 0..ROUND_CYCLES-1. At wrap, round i is compared (`attempt[i]==secret[i]`).
    - ECHO: always advance to the next round. After the last round, go to BUFF.
    - CMP: on mismatch, go to BUFF immediately; match count = i. On a match, advance; after the last round, match count = KEY_BYTES.
    - This early exit is the intended timing leak.
  - BUFF: one cycle; loads the response byte pointer.
  - SEND: `tx_tvalid`=1. Response is:
    - ECHO: KEY_BYTES bytes, byte 0 first.
    - CMP: a single byte equal to the match count (0..KEY_BYTES).
    - After the last handshake, go to IDLE.
- `rx_tvalid` bytes arriving outside IDLE/RECV are back-pressured, not dropped.
- `attempt` holds its value after a frame; the next header does not clear it, and bytes are overwritten as received.

## Timing
- Reset (async assert, sync release): state IDLE, `attempt`=0, mode ECHO, counters 0. Outputs: `rx_tready`=1, `tx_tvalid`=0, `tx_tdata`=0, `leak_data`=0, `trg`=0, `syn`=0, `busy`=0.
- Reset mid-frame or mid-RUN aborts without emitting anything. `trg` drops in the reset cycle.
- Handshakes complete on any edge with valid&&ready, and only then. Controller outputs are registered:
  - `tx_tdata` is stable while `tx_tvalid`=1 and not ready.
  - `tx_tvalid` never deasserts without a handshake.
- RUN entry is the cycle after the last RECV handshake. `trg`, `syn` and `leak_data` are registered and go high/valid on the first RUN cycle.
- RUN length:
  - ECHO: exactly KEY_BYTES*ROUND_CYCLES cycles.
  - CMP: (m+1)*ROUND_CYCLES cycles on a mismatch at byte m; KEY_BYTES*ROUND_CYCLES on a full match.
- First `tx_tvalid` is 2 cycles after the last RUN cycle (BUFF, then SEND).
- Minimum frame-to-frame gap is one cycle: IDLE accepts a header the cycle after the final tx handshake.
- Width rules:
  - Round index: $clog2(KEY_BYTES)+1 bits.
  - Cycle counter: 8 bits.
  - Match count is zero-extended to 8 bits.

## Structure
- `spa_pkg`:
  - state enum `spa_state_e` {IDLE, RECV, RUN, BUFF, SEND}.
  - mode constants `SPA_MODE_ECHO`=1'b0, `SPA_MODE_CMP`=1'b1.
  - `SPA_KEY_DEFAULT`=8'hAC for bench secrets.
- Sub-module `spa_round_ctr`:
  - Inputs: `start`, `advance_en`.
  - Outputs: cycle counter, round index, `syn`, `round_end`, `last_round`.
  - Parametrised by KEY_BYTES, ROUND_CYCLES.
- The FSM and the attempt register stay in `spa_key_ctrl`; `top` instantiates it in place of its inline FSM.

## Test plan
- Echo, KEY_BYTES=4, ROUND_CYCLES=16: send 00,11,22,33,44 → tx returns 11,22,33,44; `trg` high exactly 64 cycles; 4 `syn` pulses 16 apart.
- Compare, full match, secret=AC,AC,AC,AC: send 01,AC,AC,AC,AC → tx returns 04; `trg` high 64 cycles; `leak_data`=AC each round.
- Compare, early mismatch, same secret: send 01,AC,00,AC,AC → tx returns 01; `trg` high exactly 32 cycles; `leak_data`=AC then AC.
- Back-pressure: hold `tx_tready`=0 for 20 cycles during an echo response → `tx_tvalid` and `tx_tdata` stay constant; `rx_tready`=0 throughout; no byte lost or duplicated.
- Reset mid-RUN: deassert `rst_n` at cycle 10 of RUN → same-cycle `trg`=0, `busy`=0, `tx_tvalid`=0. The next frame 00,01,02,03,04 echoes 01,02,03,04.
- KEY_BYTES=1, ROUND_CYCLES=2: send 01,5A with secret 5A → tx returns 01 after a 2-cycle `trg` window.
